// File: rtl/ddfs_sweep_ctrl.sv
// Frequency-sweep controller for a DDFS phase accumulator: fixed tone, single,
// sawtooth or triangle FCW sweeps with a per-frequency dwell count.
module ddfs_sweep_ctrl #(
    parameter int unsigned W  = 32,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [W-1:0]  cfg_fstart,
    input  logic [W-1:0]  cfg_fstop,
    input  logic [W-1:0]  cfg_fstep,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [1:0]    cfg_mode,
    input  logic [W-1:0]  cfg_poff,
    input  logic          start,
    input  logic          stop,
    output logic [W-1:0]  pa_out,
    output logic          pa_valid,
    output logic [W-1:0]  fcw,
    output logic          busy,
    output logic          sweep_done
);

    localparam logic [1:0] MODE_FIXED  = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_SAW    = 2'b10;
    localparam logic [1:0] MODE_TRI    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_fcw;
    logic [DW-1:0]   r_dwell_cnt;
    logic [W-1:0]    r_fstart;
    logic [W-1:0]    r_fstop;
    logic [W-1:0]    r_fstep;
    logic [W-1:0]    r_poff;
    logic [DW-1:0]   r_dwell;
    logic [1:0]      r_mode;
    // Direction: 0 = increasing FCW, 1 = decreasing. r_dir_cap is the configured sense.
    logic            r_dir_cap;
    logic            r_dir;

    logic            w_cfg_hs;
    logic            w_go;
    logic            w_step_evt;
    logic            w_at_stop;
    logic            w_at_start;
    logic            w_rev;
    logic            w_done_evt;
    logic [W-1:0]    w_fcw_step;
    logic            w_dir_step;

    // One clamped FCW step toward tgt, computed with a carry/borrow bit.
    function automatic logic [W-1:0] step_toward(
        input logic [W-1:0] cur,
        input logic [W-1:0] step,
        input logic [W-1:0] tgt,
        input logic         down
    );
        logic [W:0]   sum;
        logic [W-1:0] res;
        if (!down) begin
            sum = {1'b0, cur} + {1'b0, step};
            res = (sum[W] || (sum[W-1:0] > tgt)) ? tgt : sum[W-1:0];
        end else begin
            sum = {1'b0, cur} - {1'b0, step};
            res = (sum[W] || (sum[W-1:0] < tgt)) ? tgt : sum[W-1:0];
        end
        return res;
    endfunction

    assign w_cfg_hs   = cfg_valid && (r_state == S_IDLE);
    assign w_go       = (r_state == S_IDLE) && start && !stop;
    assign w_step_evt = (r_state == S_RUN) && (r_dwell_cnt == r_dwell);
    assign w_at_stop  = (r_fcw == r_fstop);
    assign w_at_start = (r_fcw == r_fstart);
    assign w_rev      = (r_dir != r_dir_cap);

    // FCW update applied at a step event.
    always_comb begin
        w_fcw_step = r_fcw;
        w_dir_step = r_dir;
        w_done_evt = 1'b0;
        case (r_mode)
            MODE_FIXED: begin
                w_fcw_step = r_fcw;
            end
            MODE_SINGLE: begin
                if (w_at_stop) w_done_evt = 1'b1;
                else           w_fcw_step = step_toward(r_fcw, r_fstep, r_fstop, r_dir);
            end
            MODE_SAW: begin
                if (w_at_stop) w_fcw_step = r_fstart;
                else           w_fcw_step = step_toward(r_fcw, r_fstep, r_fstop, r_dir);
            end
            MODE_TRI: begin
                if (w_at_stop) begin
                    w_dir_step = ~r_dir;
                    w_fcw_step = step_toward(r_fcw, r_fstep, r_fstart, ~r_dir);
                end else if (w_rev && w_at_start) begin
                    w_dir_step = r_dir_cap;
                    w_fcw_step = step_toward(r_fcw, r_fstep, r_fstop, r_dir_cap);
                end else begin
                    w_fcw_step = step_toward(r_fcw, r_fstep, w_rev ? r_fstart : r_fstop, r_dir);
                end
            end
            default: begin
                w_fcw_step = r_fcw;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; stop outranks every other transition out of RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start && !stop) w_state_nxt = S_RUN;
            S_RUN: begin
                if (stop)                          w_state_nxt = S_IDLE;
                else if (w_step_evt && w_done_evt) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        cfg_ready  = 1'b0;
        busy       = 1'b0;
        pa_valid   = 1'b0;
        sweep_done = 1'b0;
        case (r_state)
            S_IDLE: cfg_ready = 1'b1;
            S_RUN: begin
                busy     = 1'b1;
                pa_valid = 1'b1;
            end
            S_DONE:  sweep_done = 1'b1;
            default: cfg_ready  = 1'b0;
        endcase
    end

    // Shadow config, accumulator, FCW and dwell counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_fcw       <= '0;
            r_dwell_cnt <= '0;
            r_fstart    <= '0;
            r_fstop     <= '0;
            r_fstep     <= '0;
            r_poff      <= '0;
            r_dwell     <= '0;
            r_mode      <= '0;
            r_dir_cap   <= 1'b0;
            r_dir       <= 1'b0;
        end else begin
            if (w_cfg_hs) begin
                r_fstart  <= cfg_fstart;
                r_fstop   <= cfg_fstop;
                r_fstep   <= cfg_fstep;
                r_poff    <= cfg_poff;
                r_dwell   <= cfg_dwell;
                r_mode    <= cfg_mode;
                r_dir_cap <= (cfg_fstart > cfg_fstop);
            end
            if (w_go) begin
                r_acc       <= '0;
                r_dwell_cnt <= '0;
                r_fcw       <= w_cfg_hs ? cfg_fstart : r_fstart;
                r_dir       <= w_cfg_hs ? (cfg_fstart > cfg_fstop) : r_dir_cap;
            end else if ((r_state == S_RUN) && !stop) begin
                r_acc <= r_acc + r_fcw;
                if (w_step_evt) begin
                    r_dwell_cnt <= '0;
                    r_fcw       <= w_fcw_step;
                    r_dir       <= w_dir_step;
                end else begin
                    r_dwell_cnt <= r_dwell_cnt + DW'(1);
                end
            end
        end
    end

    assign pa_out = r_acc + r_poff;
    assign fcw    = r_fcw;

endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// Bench for ddfs_sweep_ctrl: directed and randomized sweeps checked against a
// frequency-path model (list of visited FCWs, each held dwell+1 cycles).
module tb_ddfs_sweep_ctrl;

    localparam int unsigned W  = 32;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [W-1:0]  cfg_fstart;
    logic [W-1:0]  cfg_fstop;
    logic [W-1:0]  cfg_fstep;
    logic [DW-1:0] cfg_dwell;
    logic [1:0]    cfg_mode;
    logic [W-1:0]  cfg_poff;
    logic          start;
    logic          stop;
    logic [W-1:0]  pa_out;
    logic          pa_valid;
    logic [W-1:0]  fcw;
    logic          busy;
    logic          sweep_done;

    int checks = 0;
    int errors = 0;
    logic [31:0] obs_fcw [0:255];
    logic [31:0] obs_pa  [0:255];
    int          obs_done_k;

    ddfs_sweep_ctrl #(.W(W), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_fstart (cfg_fstart),
        .cfg_fstop  (cfg_fstop),
        .cfg_fstep  (cfg_fstep),
        .cfg_dwell  (cfg_dwell),
        .cfg_mode   (cfg_mode),
        .cfg_poff   (cfg_poff),
        .start      (start),
        .stop       (stop),
        .pa_out     (pa_out),
        .pa_valid   (pa_valid),
        .fcw        (fcw),
        .busy       (busy),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clamped move from cur toward tgt in exact integer arithmetic.
    function automatic logic [31:0] toward(input logic [31:0] cur, input logic [31:0] tgt,
                                           input logic [31:0] step);
        longint c, t, s;
        c = longint'(cur);
        t = longint'(tgt);
        s = longint'(step);
        if (c < t) return (c + s > t) ? tgt : 32'(c + s);
        if (c > t) return (c - s < t) ? tgt : 32'(c - s);
        return cur;
    endfunction

    task automatic check_run(input string n, input int k, input logic [31:0] ef, input logic [31:0] ep);
        chk($sformatf("%s k%0d busy", n, k), 64'(busy), 64'(1));
        chk($sformatf("%s k%0d pa_valid", n, k), 64'(pa_valid), 64'(1));
        chk($sformatf("%s k%0d sweep_done", n, k), 64'(sweep_done), 64'(0));
        chk($sformatf("%s k%0d cfg_ready", n, k), 64'(cfg_ready), 64'(0));
        chk($sformatf("%s k%0d fcw", n, k), 64'(fcw), 64'(ef));
        chk($sformatf("%s k%0d pa_out", n, k), 64'(pa_out), 64'(ep));
    endtask

    task automatic check_idle(input string n, input logic [31:0] ef, input logic [31:0] ep);
        chk({n, " busy"}, 64'(busy), 64'(0));
        chk({n, " pa_valid"}, 64'(pa_valid), 64'(0));
        chk({n, " sweep_done"}, 64'(sweep_done), 64'(0));
        chk({n, " cfg_ready"}, 64'(cfg_ready), 64'(1));
        chk({n, " fcw"}, 64'(fcw), 64'(ef));
        chk({n, " pa_out"}, 64'(pa_out), 64'(ep));
    endtask

    // Configure + start in the same IDLE cycle, then follow the sweep for up to ncyc
    // RUN cycles; ends either through DONE or by asserting stop in the last cycle.
    task automatic run_check(input string n, input logic [1:0] mode, input logic [31:0] fs,
                             input logic [31:0] fe, input logic [31:0] st, input logic [15:0] dw,
                             input logic [31:0] po, input int ncyc);
        logic [31:0] path [$];
        logic [31:0] p, acc, ef, ep;
        bit fwd, term;
        int plen, hold, idx;

        chk({n, " pre cfg_ready"}, 64'(cfg_ready), 64'(1));
        cfg_valid = 1'b1; cfg_mode = mode; cfg_fstart = fs; cfg_fstop = fe;
        cfg_fstep = st; cfg_dwell = dw; cfg_poff = po; start = 1'b1;
        tick;
        cfg_valid = 1'b0; start = 1'b0;

        p = fs; fwd = 1'b1;
        path.push_back(p);
        while (path.size() < ncyc + 2) begin
            if (mode == 2'd1) begin
                if (p == fe) break;
                p = toward(p, fe, st);
            end else if (mode == 2'd2) begin
                p = (p == fe) ? fs : toward(p, fe, st);
            end else if (mode == 2'd3) begin
                if (fwd) begin
                    if (p == fe) begin fwd = 1'b0; p = toward(p, fs, st); end
                    else p = toward(p, fe, st);
                end else begin
                    if (p == fs) begin fwd = 1'b1; p = toward(p, fe, st); end
                    else p = toward(p, fs, st);
                end
            end
            path.push_back(p);
        end
        plen = path.size();
        term = (mode == 2'd1) && (path[plen-1] == fe);
        hold = int'(dw) + 1;
        acc = '0;
        obs_done_k = -1;

        for (int k = 0; k < ncyc; k++) begin
            idx = k / hold;
            if (idx >= plen) idx = plen - 1;
            ef = path[idx];
            ep = acc + po;
            if (k < 256) begin obs_fcw[k] = fcw; obs_pa[k] = pa_out; end
            if (term && k == plen * hold) begin
                obs_done_k = k;
                chk($sformatf("%s done busy", n), 64'(busy), 64'(0));
                chk($sformatf("%s done pa_valid", n), 64'(pa_valid), 64'(0));
                chk($sformatf("%s done sweep_done", n), 64'(sweep_done), 64'(1));
                chk($sformatf("%s done cfg_ready", n), 64'(cfg_ready), 64'(0));
                chk($sformatf("%s done fcw", n), 64'(fcw), 64'(ef));
                tick;
                check_idle({n, " after_done"}, ef, ep);
                return;
            end
            check_run(n, k, ef, ep);
            if (k == ncyc - 1) begin
                stop = 1'b1;
                tick;
                stop = 1'b0;
                check_idle({n, " after_stop"}, ef, ep);
                return;
            end
            acc = acc + ef;
            tick;
        end
    endtask

    initial begin
        logic [1:0]  m;
        logic [31:0] fs, fe, st, po;
        logic [15:0] dw;
        int          nc;

        rst = 1'b1; cfg_valid = 1'b0; cfg_fstart = '0; cfg_fstop = '0; cfg_fstep = '0;
        cfg_dwell = '0; cfg_mode = '0; cfg_poff = '0; start = 1'b0; stop = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        check_idle("reset", 32'h0, 32'h0);

        // Fixed tone with phase offset, accumulator wrap at T+13.
        run_check("r043", 2'd0, 32'h1000_0000, 32'h0, 32'h0, 16'd0, 32'h4000_0000, 20);
        chk("r043 pa T+1", 64'(obs_pa[0]), 64'h4000_0000);
        chk("r043 pa T+2", 64'(obs_pa[1]), 64'h5000_0000);
        chk("r043 pa T+13", 64'(obs_pa[12]), 64'h0);
        chk("r043 fcw const", 64'(obs_fcw[19]), 64'h1000_0000);

        // Single sweep with dwell 2.
        run_check("r044", 2'd1, 32'd10, 32'd40, 32'd10, 16'd2, 32'd0, 40);
        chk("r044 done k", 64'(obs_done_k), 64'(12));
        chk("r044 fcw k2", 64'(obs_fcw[2]), 64'd10);
        chk("r044 fcw k3", 64'(obs_fcw[3]), 64'd20);
        chk("r044 fcw k6", 64'(obs_fcw[6]), 64'd30);
        chk("r044 fcw k11", 64'(obs_fcw[11]), 64'd40);

        // Triangle with clamp at the top.
        run_check("r045", 2'd3, 32'd100, 32'd130, 32'd20, 16'd0, 32'd0, 12);
        chk("r045 fcw k1", 64'(obs_fcw[1]), 64'd120);
        chk("r045 fcw k2", 64'(obs_fcw[2]), 64'd130);
        chk("r045 fcw k3", 64'(obs_fcw[3]), 64'd110);
        chk("r045 fcw k4", 64'(obs_fcw[4]), 64'd100);
        chk("r045 fcw k5", 64'(obs_fcw[5]), 64'd120);

        // Sawtooth down-sweeps: small step, then a step that would underflow.
        run_check("r046a", 2'd2, 32'hFFFF_FFF0, 32'h0, 32'h10, 16'd0, 32'h0, 10);
        chk("r046a fcw k1", 64'(obs_fcw[1]), 64'hFFFF_FFE0);
        run_check("r046b", 2'd2, 32'hFFFF_FFF0, 32'h0, 32'h7FFF_FFFF, 16'd0, 32'h5, 8);
        chk("r046b fcw k1", 64'(obs_fcw[1]), 64'h7FFF_FFF1);
        chk("r046b fcw k2", 64'(obs_fcw[2]), 64'h0);
        chk("r046b fcw k3", 64'(obs_fcw[3]), 64'hFFFF_FFF0);

        run_check("ovf", 2'd3, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h90, 16'd1, 32'h0, 16);
        chk("ovf clamp", 64'(obs_fcw[4]), 64'hFFFF_FFFF);
        run_check("tri_dn", 2'd3, 32'd500, 32'd200, 32'd70, 16'd1, 32'd9, 40);
        run_check("zstep_ne", 2'd1, 32'd5, 32'd9, 32'd0, 16'd0, 32'd0, 10);
        run_check("zstep_eq", 2'd1, 32'd5, 32'd5, 32'd0, 16'd2, 32'd0, 10);
        chk("zstep_eq done k", 64'(obs_done_k), 64'(3));

        // start and stop together in IDLE.
        start = 1'b1; stop = 1'b1;
        tick;
        start = 1'b0; stop = 1'b0;
        chk("startstop busy", 64'(busy), 64'(0));
        chk("startstop cfg_ready", 64'(cfg_ready), 64'(1));

        // Config offered during RUN must not reach the shadow registers.
        cfg_valid = 1'b1; cfg_mode = 2'd0; cfg_fstart = 32'd5; cfg_poff = 32'h100; start = 1'b1;
        tick;
        start = 1'b0;
        cfg_mode = 2'd1; cfg_fstart = 32'h99; cfg_poff = 32'h777;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("cfgrun cfg_ready %0d", i), 64'(cfg_ready), 64'(0));
            chk($sformatf("cfgrun fcw %0d", i), 64'(fcw), 64'd5);
            tick;
        end
        cfg_valid = 1'b0; stop = 1'b1;
        tick;
        stop = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        chk("cfgrun restart fcw", 64'(fcw), 64'd5);
        chk("cfgrun restart pa", 64'(pa_out), 64'h100);
        tick;
        chk("cfgrun restart pa2", 64'(pa_out), 64'h105);
        stop = 1'b1;
        tick;
        stop = 1'b0;

        // DONE lasts one cycle, start there is ignored, held start restarts from IDLE.
        cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_fstart = 32'd7; cfg_fstop = 32'd7;
        cfg_fstep = 32'd0; cfg_dwell = 16'd0; cfg_poff = 32'd0; start = 1'b1;
        tick;
        cfg_valid = 1'b0;
        chk("hold run busy", 64'(busy), 64'(1));
        tick;
        chk("hold done pulse", 64'(sweep_done), 64'(1));
        chk("hold done pa_valid", 64'(pa_valid), 64'(0));
        tick;
        chk("hold idle busy", 64'(busy), 64'(0));
        chk("hold idle cfg_ready", 64'(cfg_ready), 64'(1));
        chk("hold idle sweep_done", 64'(sweep_done), 64'(0));
        tick;
        chk("hold restart busy", 64'(busy), 64'(1));
        chk("hold restart pa", 64'(pa_out), 64'd0);
        start = 1'b0; stop = 1'b1;
        tick;
        stop = 1'b0;

        // stop coinciding with the final step event of a single sweep.
        cfg_valid = 1'b1; cfg_fstart = 32'd9; cfg_fstop = 32'd9; cfg_dwell = 16'd1; start = 1'b1;
        tick;
        cfg_valid = 1'b0; start = 1'b0;
        tick;
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("stopfinal sweep_done", 64'(sweep_done), 64'(0));
        chk("stopfinal busy", 64'(busy), 64'(0));
        tick;
        chk("stopfinal sweep_done2", 64'(sweep_done), 64'(0));

        // Reset mid-RUN, then a start with no config since reset.
        cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_fstart = 32'd3; cfg_fstop = 32'd50;
        cfg_fstep = 32'd7; cfg_dwell = 16'd0; cfg_poff = 32'h1234; start = 1'b1;
        tick;
        cfg_valid = 1'b0; start = 1'b0;
        repeat (5) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_idle("rstmid", 32'h0, 32'h0);
        tick;
        chk("rstmid sweep_done", 64'(sweep_done), 64'(0));
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_run("noconf", i, 32'h0, 32'h0);
            tick;
        end
        stop = 1'b1;
        tick;
        stop = 1'b0;

        // Randomized sweeps.
        for (int i = 0; i < 14; i++) begin
            m  = 2'($urandom_range(0, 3));
            dw = 16'($urandom_range(0, 3));
            po = $urandom;
            nc = int'($urandom_range(10, 60));
            if ($urandom_range(0, 3) == 0) begin
                fs = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
                fe = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : (32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
                st = 32'($urandom_range(1, 400));
            end else begin
                fs = 32'($urandom_range(0, 1000));
                fe = 32'($urandom_range(0, 1000));
                st = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
            end
            run_check($sformatf("rnd%0d", i), m, fs, fe, st, dw, po, nc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
